// File: rtl/connect_suite_pipe_chain.sv
`default_nettype none
// ============================================================================
// Module   : connect_suite_pipe_chain
// Purpose  : Cascade of STAGES valid/ready register slices carrying a
//            WIDTH-bit payload. The ready path is combinational through the
//            whole chain, so empty slots collapse (no bubbles) and a full
//            chain streams one beat per cycle while the consumer is ready.
//            Synchronous flush drops all beats. Asynchronous active-low
//            reset clears all state immediately.
// Ports    : clk           - clock, rising edge
//            reset         - asynchronous reset, active low
//            io_in_valid   - producer has a beat
//            io_in_ready   - chain accepts the beat this cycle
//            io_in_bits    - producer payload
//            io_out_valid  - last stage holds a beat
//            io_out_ready  - consumer accepts this cycle
//            io_out_bits   - last-stage payload
//            io_flush      - synchronous clear of every stage
//            io_count      - number of occupied stages (0..STAGES)
// Revision : 1.0 - initial release
// ============================================================================
module connect_suite_pipe_chain #(
  parameter  int WIDTH  = 8,
  parameter  int STAGES = 3,
  localparam int CW     = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_bits,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_bits,
  input  logic             io_flush,
  output logic [CW-1:0]    io_count
);

  // Stage 0 is the input side, stage STAGES-1 drives the outputs.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [WIDTH-1:0]  d_d [STAGES];

  // rdy[k]: stage k may load this cycle. rdy[STAGES] is the consumer.
  logic [STAGES:0]   rdy;
  logic [CW-1:0]     count_w;

  // A stage can load if it is empty or everything downstream of it moves.
  always_comb begin
    rdy[STAGES] = io_out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !v_q[k] || rdy[k+1];
    end
  end

  always_comb begin
    v_d = v_q;
    for (int k = 0; k < STAGES; k++) begin
      d_d[k] = d_q[k];
    end
    if (rdy[0]) begin
      v_d[0] = io_in_valid;
      d_d[0] = io_in_bits;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (rdy[k]) begin
        v_d[k] = v_q[k-1];
        d_d[k] = d_q[k-1];
      end
    end
    // Flush only kills the valid bits; the data registers are don't-care.
    if (io_flush) begin
      v_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < STAGES; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

  always_comb begin
    count_w = '0;
    for (int k = 0; k < STAGES; k++) begin
      count_w = count_w + CW'(v_q[k]);
    end
  end

  assign io_in_ready  = rdy[0];
  assign io_out_valid = v_q[STAGES-1];
  assign io_out_bits  = d_q[STAGES-1];
  assign io_count     = count_w;

endmodule
`default_nettype wire

// File: tb/tb_connect_suite_pipe_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_connect_suite_pipe_chain
// Purpose  : Self-checking bench for connect_suite_pipe_chain (WIDTH=8,
//            STAGES=3). Directed vector table, hand-written reset
//            sequences, and a randomized run against a slot/queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_connect_suite_pipe_chain;
  localparam int W  = 8;
  localparam int S  = 3;
  localparam int CW = $clog2(S + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_bits;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_bits;
  logic          flush;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  connect_suite_pipe_chain #(.WIDTH(W), .STAGES(S)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (in_valid),
    .io_in_ready  (in_ready),
    .io_in_bits   (in_bits),
    .io_out_valid (out_valid),
    .io_out_ready (out_ready),
    .io_out_bits  (out_bits),
    .io_flush     (flush),
    .io_count     (count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         iv;
    logic [W-1:0] ib;
    logic         ordy;
    logic         fl;
    logic         ev;
    logic [W-1:0] eb;
    logic         erdy;
    logic [CW-1:0] ecnt;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  function automatic vec_t mk(input int iv, input int ib, input int ordy, input int fl,
                              input int ev, input int eb, input int erdy, input int ecnt);
    vec_t v;
    v.iv   = iv[0];
    v.ib   = ib[W-1:0];
    v.ordy = ordy[0];
    v.fl   = fl[0];
    v.ev   = ev[0];
    v.eb   = eb[W-1:0];
    v.erdy = erdy[0];
    v.ecnt = ecnt[CW-1:0];
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Slot occupancy plus an arrival-order queue of accepted beats.
  bit           mv [S];
  logic [W-1:0] md [S];
  logic [W-1:0] sb [$];

  function automatic bit m_free(input int k);
    if (out_ready) return 1'b1;
    for (int j = k; j < S; j++) if (!mv[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int j = 0; j < S; j++) c += int'(mv[j]);
    return c;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < S; j++) begin
      mv[j] = 1'b0;
      md[j] = '0;
    end
    sb.delete();
  endtask

  task automatic model_check(input int cyc);
    chk($sformatf("rnd%0d_out_valid", cyc), out_valid, mv[S-1]);
    if (mv[S-1]) begin
      chk($sformatf("rnd%0d_out_bits", cyc), out_bits, md[S-1]);
      if (sb.size() > 0) chk($sformatf("rnd%0d_order", cyc), out_bits, sb[0]);
    end
    chk($sformatf("rnd%0d_in_ready", cyc), in_ready, m_free(0));
    chk($sformatf("rnd%0d_count", cyc), count, m_count());
  endtask

  task automatic model_edge();
    bit           nv [S];
    logic [W-1:0] nd [S];
    if (flush) begin
      for (int j = 0; j < S; j++) mv[j] = 1'b0;
      sb.delete();
      return;
    end
    if (mv[S-1] && out_ready && sb.size() > 0) void'(sb.pop_front());
    if (in_valid && m_free(0)) sb.push_back(in_bits);
    for (int k = 0; k < S; k++) begin
      nv[k] = mv[k];
      nd[k] = md[k];
      if (m_free(k)) begin
        if (k == 0) begin
          nv[k] = in_valid;
          nd[k] = in_bits;
        end else begin
          nv[k] = mv[k-1];
          nd[k] = md[k-1];
        end
      end
    end
    for (int k = 0; k < S; k++) begin
      mv[k] = nv[k];
      md[k] = nd[k];
    end
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] ib, input logic ordy, input logic fl);
    in_valid  = iv;
    in_bits   = ib;
    out_ready = ordy;
    flush     = fl;
  endtask

  logic         pending;
  logic         acc;

  initial begin
    // streaming 0x11..0x44 with consumer ready
    tbl[0]  = mk(1, 'h11, 1, 0, 0, 'h00, 1, 0);
    tbl[1]  = mk(1, 'h22, 1, 0, 0, 'h00, 1, 1);
    tbl[2]  = mk(1, 'h33, 1, 0, 0, 'h00, 1, 2);
    tbl[3]  = mk(1, 'h44, 1, 0, 1, 'h11, 1, 3);
    tbl[4]  = mk(0, 'h00, 1, 0, 1, 'h22, 1, 3);
    tbl[5]  = mk(0, 'h00, 1, 0, 1, 'h33, 1, 2);
    tbl[6]  = mk(0, 'h00, 1, 0, 1, 'h44, 1, 1);
    tbl[7]  = mk(0, 'h00, 1, 0, 0, 'h00, 1, 0);
    // fill under back-pressure, then drain
    tbl[8]  = mk(1, 'hA0, 0, 0, 0, 'h00, 1, 0);
    tbl[9]  = mk(1, 'hA1, 0, 0, 0, 'h00, 1, 1);
    tbl[10] = mk(1, 'hA2, 0, 0, 0, 'h00, 1, 2);
    tbl[11] = mk(1, 'hA3, 0, 0, 1, 'hA0, 0, 3);
    tbl[12] = mk(1, 'hA3, 0, 0, 1, 'hA0, 0, 3);
    tbl[13] = mk(1, 'hA3, 1, 0, 1, 'hA0, 1, 3);
    tbl[14] = mk(1, 'hA4, 1, 0, 1, 'hA1, 1, 3);
    tbl[15] = mk(0, 'h00, 1, 0, 1, 'hA2, 1, 3);
    tbl[16] = mk(0, 'h00, 1, 0, 1, 'hA3, 1, 2);
    tbl[17] = mk(0, 'h00, 1, 0, 1, 'hA4, 1, 1);
    tbl[18] = mk(0, 'h00, 0, 0, 0, 'h00, 1, 0);
    // bubble collapse with consumer stalled
    tbl[19] = mk(1, 'h01, 0, 0, 0, 'h00, 1, 0);
    tbl[20] = mk(0, 'h00, 0, 0, 0, 'h00, 1, 1);
    tbl[21] = mk(0, 'h00, 0, 0, 0, 'h00, 1, 1);
    tbl[22] = mk(1, 'h02, 0, 0, 1, 'h01, 1, 1);
    tbl[23] = mk(0, 'h00, 0, 0, 1, 'h01, 1, 2);
    tbl[24] = mk(1, 'h03, 0, 0, 1, 'h01, 1, 2);
    // flush with three beats held and 0x55 offered
    tbl[25] = mk(1, 'h55, 1, 1, 1, 'h01, 1, 3);
    tbl[26] = mk(0, 'h00, 1, 0, 0, 'h00, 1, 0);
    tbl[27] = mk(0, 'h00, 1, 0, 0, 'h00, 1, 0);
    tbl[28] = mk(0, 'h00, 1, 0, 0, 'h00, 1, 0);

    // ---- reset asserted with no clock edge yet ----
    drive(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("por_out_valid", out_valid, 0);
    chk("por_count", count, 0);
    chk("por_in_ready", in_ready, 1);
    chk("por_out_bits", out_bits, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // ---- idle after release: nothing changes ----
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("idle%0d_count", i), count, 0);
      chk($sformatf("idle%0d_out_valid", i), out_valid, 0);
    end

    // ---- directed table ----
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].iv, tbl[i].ib, tbl[i].ordy, tbl[i].fl);
      #1;
      chk($sformatf("row%0d_out_valid", i), out_valid, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("row%0d_out_bits", i), out_bits, tbl[i].eb);
      chk($sformatf("row%0d_in_ready", i), in_ready, tbl[i].erdy);
      chk($sformatf("row%0d_count", i), count, tbl[i].ecnt);
    end

    // ---- asynchronous reset between edges with beats in flight ----
    @(negedge clk);
    drive(1'b1, 8'hC1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'hC2, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0);
    #1 chk("pre_rst_count", count, 2);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_bits", out_bits, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // ---- randomized run against the model, with a mid-stream reset ----
    pending = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (i == 300) begin
        #2 reset = 1'b0;
        #1;
        chk("rnd_rst_out_valid", out_valid, 0);
        chk("rnd_rst_count", count, 0);
        chk("rnd_rst_in_ready", in_ready, 1);
        model_reset();
        pending = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        continue;
      end
      if (!pending) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_bits  = W'($urandom);
      end
      if (i >= 100 && i < 200) out_ready = ($urandom_range(0, 4) == 0);
      else                     out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 29) == 0);
      #1;
      model_check(i);
      acc     = in_valid && m_free(0);
      pending = in_valid && !acc && !flush;
      model_edge();
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/connect_suite_pipe_chain.md
# connect_suite_pipe_chain

Parametrised successor to the nested pass-through chain. It carries a WIDTH-bit payload through STAGES cascaded register slices, each with its own valid/ready handshake. It keeps the chain's port-to-port topology and adds buffering, back-pressure, flush and occupancy reporting. It sits between a producer and a consumer that both use valid/ready.

## Interface
- WIDTH, default 8: payload width in bits, ≥1.
- STAGES, default 3: number of register slices, ≥1. This is also the capacity in beats.
- CW, derived as clog2(STAGES+1): width of io_count.

Ports:
- clk  input  1  sole clock; all state is updated on its rising edge.
- reset  input  1  asynchronous, active-low reset: asserting it (0) clears state immediately; deassertion is sampled on clk.
- io_in_valid  input  1  producer has a beat.
- io_in_ready  output  1  chain accepts the beat this cycle.
- io_in_bits  input  WIDTH  producer payload.
- io_out_valid  output  1  the last stage holds a beat.
- io_out_ready  input  1  consumer accepts this cycle.
- io_out_bits  output  WIDTH  last-stage payload.
- io_flush  input  1  synchronous clear of all stages.
- io_count  output  CW  number of occupied stages, 0..STAGES.

## Operation
- Stage k (0..STAGES-1) holds v[k] (valid) and d[k] (WIDTH bits). Stage 0 is the input side.
- rdy[STAGES] = io_out_ready.
- rdy[k] = !v[k] | rdy[k+1]. This ready path is combinational through the chain.
- io_in_ready = rdy[0].
- io_out_valid = v[STAGES-1] and io_out_bits = d[STAGES-1].
- Stage 0 loads when rdy[0]: v[0] ← io_in_valid, d[0] ← io_in_bits.
- Stage k>0 loads when rdy[k]: v[k] ← v[k-1], d[k] ← d[k-1].
- Stages with rdy[k]=0 hold their value.
- d[k] may load don't-care data when the incoming valid is 0. Bench checks bits only when valid=1.
- io_count = popcount(v). It is combinational from the registers and shows the state after the most recent edge.
- Flush: if io_flush=1 at an edge, every v[k] ← 0 and any input beat offered that cycle is dropped.
  - io_in_ready is still driven per the formula during flush. Producers must not rely on acceptance in a flush cycle.
- Reset (reset=0, asynchronous):
  - v[k]=0 and d[k]=0 immediately, even mid-transfer. In-flight beats are discarded.
  - Outputs during and after reset: io_out_valid=0, io_out_bits=0, io_count=0, io_in_ready=1.
- Ordering: beats exit in arrival order. No beat is duplicated or lost except through flush or reset.
- Priority: reset > flush > normal transfer.

## Timing
- Latency on an empty chain with io_out_ready=1: a beat accepted at edge n appears on io_out_valid after edge n+STAGES-1, i.e. STAGES cycles from presentation to visibility.
- Throughput: 1 beat/cycle sustained when io_out_ready=1. There are no bubbles.
- Full: all STAGES stages valid and io_out_ready=0 gives io_in_ready=0 in the same cycle.
- Full with io_out_ready=1: io_in_ready=1, and the chain accepts and emits in the same cycle, so count stays STAGES.
- Empty with io_in_valid=0: count=0 and io_out_valid=0.
- Consumer stall with a gap in the chain: upstream stages keep advancing into empty slots (bubble collapse), so count rises by 1 per accepted beat.
- Combinational paths:
  - io_out_ready → io_in_ready, through STAGES OR gates.
  - There is no combinational path from io_in_* to any output.
- Handshake rules:
  - Once io_out_valid=1 it stays 1 with stable io_out_bits until io_out_ready=1 at an edge, unless flush or reset intervenes.
  - The producer keeps io_in_valid and io_in_bits stable until accepted.

## Test plan
- Reset/idle (STAGES=3, WIDTH=8):
  - Assert reset mid-cycle with no clock edge → io_out_valid=0, io_count=0, io_in_ready=1 immediately.
  - Release reset → state is unchanged until the first input beat.
- Latency/streaming:
  - Drive 0x11,0x22,0x33,0x44 on consecutive cycles with io_out_ready=1.
  - Required: 0x11 valid 3 cycles after it is presented, then one beat per cycle in order, with io_count steady at 3 during the stream.
- Fill and back-pressure:
  - With io_out_ready=0, offer 0xA0..0xA4.
  - Required: 0xA0..0xA2 accepted; io_in_ready=0 once io_count=3; io_out_bits=0xA0 held stable.
  - Raise io_out_ready → 0xA0,0xA1,0xA2,0xA3,0xA4 drain in order, with none lost.
- Bubble collapse:
  - Send 0x01, idle 2 cycles, send 0x02, with io_out_ready=0.
  - Required: io_count reaches 2 and the two beats occupy stages 2 and 1, with no gap.
- Flush:
  - With 3 beats held, pulse io_flush=1 with io_in_valid=1 carrying 0x55.
  - Required: next cycle io_count=0 and io_out_valid=0; 0x55 never appears at the output.
- Reset mid-stream:
  - During a streaming run, assert reset between edges.
  - Required: io_out_valid drops immediately; after release, only beats presented post-release emerge.
